// File: rtl/cpu_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package cpu_pkg;

  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned STARVE_W       = 4;
  localparam int unsigned LAT_W          = 3;
  localparam int unsigned RAM_LAT_DEF    = 1;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Access latched from the winning requester in IDLE.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_cmd_t;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] cnt,
                                                  input logic [STARVE_W-1:0] max);
    return (cnt >= max) ? max : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, MEM-stage and RAM-side signals of the memory port arbiter.
interface mem_port_arbiter_if;
  import cpu_pkg::*;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_data_o;
  logic              if_stall_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_ack_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_stall_o;

  logic              ram_en_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [DATA_W-1:0] ram_wdata_o;
  logic [DATA_W-1:0] ram_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ack_o, if_data_o, if_stall_o,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output mem_ack_o, mem_rdata_o, mem_stall_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ack_o, if_data_o, if_stall_o,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  mem_ack_o, mem_rdata_o, mem_stall_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/arb_priority_pick.sv
// MEM-over-IF priority with a saturating starvation counter that lets IF win.
module arb_priority_pick
  import cpu_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                i_if_req,
  input  logic                i_mem_req,
  input  logic [STARVE_W-1:0] i_starve_cnt,
  output owner_e              o_grant_c,
  output logic [STARVE_W-1:0] o_starve_cnt_c
);

  logic w_if_wins;

  assign w_if_wins = i_if_req & (~i_mem_req | (i_starve_cnt == STARVE_W'(STARVE_MAX)));

  always_comb begin
    o_grant_c      = OWN_MEM;
    o_starve_cnt_c = '0;
    if (w_if_wins) begin
      o_grant_c = OWN_IF;
    end else if (i_if_req) begin
      o_starve_cnt_c = sat_inc(i_starve_cnt, STARVE_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one single-ported RAM.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned RAM_LAT    = RAM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic               clk_i,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  state_e              r_state,       w_state_nxt;
  owner_e              r_owner,       w_owner_nxt;
  ram_cmd_t            r_cmd,         w_cmd_nxt;
  logic                r_ram_en,      w_ram_en_nxt;
  logic                r_ram_we,      w_ram_we_nxt;
  logic                r_if_ack,      w_if_ack_nxt;
  logic                r_mem_ack,     w_mem_ack_nxt;
  logic [DATA_W-1:0]   r_if_data,     w_if_data_nxt;
  logic [DATA_W-1:0]   r_mem_rdata,   w_mem_rdata_nxt;
  logic [STARVE_W-1:0] r_starve_cnt,  w_starve_nxt;
  logic [LAT_W-1:0]    r_lat_cnt,     w_lat_nxt;

  owner_e              w_grant;
  logic [STARVE_W-1:0] w_pick_starve;
  logic                w_any_req;

  assign w_any_req = bus.if_req_i | bus.mem_req_i;

  arb_priority_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_if_req       (bus.if_req_i),
    .i_mem_req      (bus.mem_req_i),
    .i_starve_cnt   (r_starve_cnt),
    .o_grant_c      (w_grant),
    .o_starve_cnt_c (w_pick_starve)
  );

  // Next-state and next-output logic; ram_en/ack are one-cycle pulses by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_cmd_nxt       = r_cmd;
    w_ram_en_nxt    = 1'b0;
    w_ram_we_nxt    = 1'b0;
    w_if_ack_nxt    = 1'b0;
    w_mem_ack_nxt   = 1'b0;
    w_if_data_nxt   = r_if_data;
    w_mem_rdata_nxt = r_mem_rdata;
    w_starve_nxt    = r_starve_cnt;
    w_lat_nxt       = r_lat_cnt;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt  = ST_ISSUE;
          w_owner_nxt  = w_grant;
          w_starve_nxt = w_pick_starve;
          w_ram_en_nxt = 1'b1;
          if (w_grant == OWN_MEM) begin
            w_cmd_nxt.we    = bus.mem_we_i;
            w_cmd_nxt.addr  = bus.mem_addr_i;
            w_cmd_nxt.wdata = bus.mem_wdata_i;
          end else begin
            w_cmd_nxt.we    = 1'b0;
            w_cmd_nxt.addr  = bus.if_addr_i;
            w_cmd_nxt.wdata = '0;
          end
          w_ram_we_nxt = w_cmd_nxt.we;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_lat_nxt   = '0;
      end
      ST_WAIT: begin
        // Read data is valid in the last WAIT cycle; capture it on leaving.
        if (r_lat_cnt == LAT_W'(RAM_LAT - 1)) begin
          w_state_nxt = ST_ACK;
          if (r_owner == OWN_IF) begin
            w_if_ack_nxt  = 1'b1;
            w_if_data_nxt = bus.ram_rdata_i;
          end else begin
            w_mem_ack_nxt = 1'b1;
            if (!r_cmd.we) begin
              w_mem_rdata_nxt = bus.ram_rdata_i;
            end
          end
        end else begin
          w_lat_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_cmd        <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
      r_starve_cnt <= '0;
      r_lat_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_cmd        <= w_cmd_nxt;
      r_ram_en     <= w_ram_en_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_if_ack     <= w_if_ack_nxt;
      r_mem_ack    <= w_mem_ack_nxt;
      r_if_data    <= w_if_data_nxt;
      r_mem_rdata  <= w_mem_rdata_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_lat_cnt    <= w_lat_nxt;
    end
  end

  assign bus.ram_en_o    = r_ram_en;
  assign bus.ram_we_o    = r_ram_we;
  assign bus.ram_addr_o  = r_cmd.addr;
  assign bus.ram_wdata_o = r_cmd.wdata;
  assign bus.if_ack_o    = r_if_ack;
  assign bus.if_data_o   = r_if_data;
  assign bus.mem_ack_o   = r_mem_ack;
  assign bus.mem_rdata_o = r_mem_rdata;
  assign bus.if_stall_o  = bus.if_req_i & ~r_if_ack;
  assign bus.mem_stall_o = bus.mem_req_i & ~r_mem_ack;

endmodule
